// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer between two requesters and one 8-deep stack.
// It drives the stack strobes, captures pop data and returns ack/err per transaction.
module stack_arbiter #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          req0,
   input  logic          req1,
   input  logic          op0,
   input  logic          op1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy,
   output logic          owner,
   output logic          stk_push,
   output logic          stk_pop,
   output logic [DW-1:0] stk_data_in,
   input  logic [DW-1:0] stk_data_out,
   input  logic          stk_full,
   input  logic          stk_empty
);

   typedef enum logic [2:0] {IDLE, PUSH, POP, CAPT, RESP} state_t;

   state_t        state, state_nx;
   logic          err_q, last;
   logic [DW-1:0] wd_q;
   logic          any_req, win, win_op, win_refuse;

   // On a tie the requester that did not win last time gets the stack.
   always_comb begin
      any_req    = req0 | req1;
      win        = (req0 & req1) ? ~last : req1;
      win_op     = win ? op1 : op0;
      win_refuse = win_op ? stk_empty : stk_full;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= IDLE;
      else       state <= state_nx;
   end

   // Strobes and ack come only from the state register, so reset kills them at once.
   always_comb begin
      state_nx = state;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE: if (any_req) state_nx = win_refuse ? RESP : (win_op ? POP : PUSH);
         PUSH: begin
            stk_push = 1'b1;
            state_nx = RESP;
         end
         POP: begin
            stk_pop  = 1'b1;
            state_nx = CAPT;
         end
         CAPT: state_nx = RESP;
         RESP: begin
            ack0     = ~owner;
            ack1     = owner;
            err      = err_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy        = (state != IDLE);
   assign stk_data_in = wd_q;

   // The granted op is carried by the PUSH/POP state itself, so no op register is kept.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         owner <= 1'b0;
         wd_q  <= '0;
         err_q <= 1'b0;
         last  <= 1'b1;
         rdata <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            owner <= win;
            wd_q  <= win ? wdata1 : wdata0;
            err_q <= win_refuse;
            last  <= win;
         end
         if (state == CAPT) rdata <= stk_data_out;
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: behavioural stack on the far side,
// queue-based reference model of grant order, latency, err and rdata.
module tb_stack_arbiter;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          ack0, ack1, err, busy, owner, stk_push, stk_pop, stk_full, stk_empty;
   logic [DW-1:0] rdata, stk_data_in, stk_data_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stack_arbiter #(.DW(DW)) dut (
      .clk(clk), .rstN(rstN),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
      .busy(busy), .owner(owner),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
      .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty)
   );

   // behavioural 8 x DW stack with registered data_out and flags
   logic [DW-1:0] smem [8];
   int            sp;
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sp           <= 0;
         stk_data_out <= '0;
      end else if (stk_push && sp < 8) begin
         smem[sp] <= stk_data_in;
         sp       <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_data_out <= smem[sp-1];
         sp           <= sp - 1;
      end
   end
   assign stk_full  = (sp == 8);
   assign stk_empty = (sp == 0);

   int npush = 0, npop = 0, nboth = 0;
   always @(negedge clk) begin
      if (stk_push) npush <= npush + 1;
      if (stk_pop)  npop  <= npop + 1;
      if (stk_push && stk_pop) nboth <= nboth + 1;
   end

   // reference model
   logic [DW-1:0] mq [$];
   bit            last_m = 1'b1;
   logic [DW-1:0] rd_m = '0;

   task automatic model_step(input bit w, input bit op, input logic [DW-1:0] d,
                             output bit e_err, output int e_lat, output int e_push, output int e_pop);
      last_m = w;
      e_push = 0;
      e_pop  = 0;
      if (!op) begin
         if (mq.size() == 8) begin e_err = 1; e_lat = 1; end
         else begin e_err = 0; e_lat = 2; e_push = 1; mq.push_back(d); end
      end else begin
         if (mq.size() == 0) begin e_err = 1; e_lat = 1; end
         else begin e_err = 0; e_lat = 3; e_pop = 1; rd_m = mq.pop_back(); end
      end
   endtask

   task automatic grant_wait(output int lat, output bit a0, output bit a1, output bit e,
                             output logic [DW-1:0] rd, output bit own, output int dp, output int dq);
      int p0 = npush;
      int q0 = npop;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(ack0 || ack1) && lat < 8);
      a0 = ack0; a1 = ack1; e = err; rd = rdata; own = owner;
      dp = npush - p0; dq = npop - q0;
   endtask

   task automatic do_reset();
      req0 = 0; req1 = 0;
      rstN = 0;
      mq.delete(); last_m = 1; rd_m = '0;
      repeat (2) @(negedge clk);
      rstN = 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({ack0, ack1, err, busy, owner, stk_push, stk_pop, rdata, stk_data_in} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {ack0, ack1, err, busy, owner, stk_push, stk_pop, rdata, stk_data_in});
      end
      @(negedge clk); rstN = 1; @(negedge clk);
   endtask

   task automatic test_single_push();
      bit ee, a0, a1, e, own; int el, ep, eq, lat, dp, dq; logic [DW-1:0] rd;
      req0 = 1; op0 = 0; wdata0 = 4'hA;
      model_step(0, 0, 4'hA, ee, el, ep, eq);
      grant_wait(lat, a0, a1, e, rd, own, dp, dq);
      req0 = 0;
      tests++; if ({a0, a1} !== 2'b10) begin fails++; $display("FAIL push_ack: got %b expected 10", {a0, a1}); end
      tests++; if (lat !== el) begin fails++; $display("FAIL push_lat: got %0d expected %0d", lat, el); end
      tests++; if (e !== ee) begin fails++; $display("FAIL push_err: got %0d expected %0d", e, ee); end
      tests++; if (dp !== ep || dq !== eq) begin fails++; $display("FAIL push_strobes: got %0d/%0d expected %0d/%0d", dp, dq, ep, eq); end
   endtask

   task automatic test_push_pop();
      bit ee, a0, a1, e, own; int el, ep, eq, lat, dp, dq; logic [DW-1:0] rd;
      @(negedge clk);
      req1 = 1; op1 = 1;
      model_step(1, 1, '0, ee, el, ep, eq);
      grant_wait(lat, a0, a1, e, rd, own, dp, dq);
      req1 = 0;
      tests++; if ({a0, a1} !== 2'b01) begin fails++; $display("FAIL pop_ack: got %b expected 01", {a0, a1}); end
      tests++; if (lat !== el) begin fails++; $display("FAIL pop_lat: got %0d expected %0d", lat, el); end
      tests++; if (rd !== rd_m || e !== ee) begin fails++; $display("FAIL pop_data: got %h/%0d expected %h/%0d", rd, e, rd_m, ee); end
      tests++; if (dp !== ep || dq !== eq) begin fails++; $display("FAIL pop_strobes: got %0d/%0d expected %0d/%0d", dp, dq, ep, eq); end
   endtask

   task automatic test_pop_empty();
      bit ee, a0, a1, e, own; int el, ep, eq, lat, dp, dq; logic [DW-1:0] rd;
      do_reset();
      req0 = 1; op0 = 1;
      model_step(0, 1, '0, ee, el, ep, eq);
      grant_wait(lat, a0, a1, e, rd, own, dp, dq);
      req0 = 0;
      tests++; if (a0 !== 1'b1 || lat !== el || e !== ee) begin fails++; $display("FAIL empty_pop: got ack=%0d lat=%0d err=%0d expected 1/%0d/%0d", a0, lat, e, el, ee); end
      tests++; if (dq !== 0 || rd !== rd_m) begin fails++; $display("FAIL empty_side: got pops=%0d rdata=%h expected 0/%h", dq, rd, rd_m); end
   endtask

   task automatic test_contention();
      bit ee, a0, a1, e, own, w; int el, ep, eq, lat, dp, dq; logic [DW-1:0] rd;
      do_reset();
      req0 = 1; req1 = 1; op0 = 0; op1 = 0; wdata0 = 4'h1; wdata1 = 4'h2;
      for (int k = 0; k < 4; k++) begin
         w = ~last_m;
         model_step(w, 0, w ? 4'h2 : 4'h1, ee, el, ep, eq);
         grant_wait(lat, a0, a1, e, rd, own, dp, dq);
         tests++; if ({a0, a1} !== {~w, w} || own !== w) begin fails++; $display("FAIL cont_grant%0d: got ack=%b owner=%0d expected owner %0d", k, {a0, a1}, own, w); end
         tests++; if (lat !== el + (k > 0 ? 1 : 0) || e !== ee || dp !== ep) begin fails++; $display("FAIL cont_txn%0d: got lat=%0d err=%0d push=%0d", k, lat, e, dp); end
      end
      req0 = 0; req1 = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req0 = 1; op0 = 1;
         model_step(0, 1, '0, ee, el, ep, eq);
         grant_wait(lat, a0, a1, e, rd, own, dp, dq);
         req0 = 0;
         tests++; if (rd !== rd_m || e !== ee) begin fails++; $display("FAIL cont_pop%0d: got %h expected %h", k, rd, rd_m); end
      end
   endtask

   task automatic test_full();
      bit ee, a0, a1, e, own, w; int el, ep, eq, lat, dp, dq; logic [DW-1:0] rd, d;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         w = 1'($urandom_range(0, 1)); d = DW'($urandom);
         if (w) begin req1 = 1; op1 = 0; wdata1 = d; end
         else   begin req0 = 1; op0 = 0; wdata0 = d; end
         model_step(w, 0, d, ee, el, ep, eq);
         grant_wait(lat, a0, a1, e, rd, own, dp, dq);
         req0 = 0; req1 = 0;
         tests++; if (lat !== el || e !== ee || dp !== ep) begin fails++; $display("FAIL full_push%0d: got lat=%0d err=%0d push=%0d expected %0d/%0d/%0d", k, lat, e, dp, el, ee, ep); end
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         req1 = 1; op1 = 1;
         model_step(1, 1, '0, ee, el, ep, eq);
         grant_wait(lat, a0, a1, e, rd, own, dp, dq);
         req1 = 0;
         tests++; if (rd !== rd_m || e !== ee) begin fails++; $display("FAIL full_pop%0d: got %h expected %h", k, rd, rd_m); end
      end
   endtask

   task automatic test_mid_reset();
      bit ee, a0, a1, e, own, seen; int el, ep, eq, lat, dp, dq; logic [DW-1:0] rd;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req1 = 1; op1 = 0; wdata1 = DW'(k + 5);
         model_step(1, 0, DW'(k + 5), ee, el, ep, eq);
         grant_wait(lat, a0, a1, e, rd, own, dp, dq);
         req1 = 0;
      end
      @(negedge clk);
      req0 = 1; op0 = 1;
      @(negedge clk);
      tests++; if (stk_pop !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_pop_start: got pop=%0d busy=%0d expected 1/1", stk_pop, busy); end
      #2 rstN = 0;
      #1;
      tests++;
      if ({stk_pop, stk_push, ack0, ack1, err, busy, owner, rdata} !== '0) begin
         fails++; $display("FAIL mid_reset_outputs: got %b expected all zero", {stk_pop, stk_push, ack0, ack1, err, busy, owner, rdata});
      end
      req0 = 0;
      seen = 0;
      repeat (3) begin @(negedge clk); if (ack0 || ack1) seen = 1; end
      rstN = 1;
      mq.delete(); last_m = 1; rd_m = '0;
      repeat (3) begin @(negedge clk); if (ack0 || ack1) seen = 1; end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_reset_noack: got ack seen=%0d expected 0", seen); end
   endtask

   task automatic test_random();
      bit ee, a0, a1, e, own, w, p0, p1, o0, o1; int el, ep, eq, lat, dp, dq, extra, pct;
      logic [DW-1:0] rd, d0, d1;
      for (int it = 0; it < 80; it++) begin
         repeat ($urandom_range(1, 2)) @(negedge clk);
         pct = (it < 40) ? 75 : 25;
         o0 = ($urandom_range(0, 99) >= pct); o1 = ($urandom_range(0, 99) >= pct);
         d0 = DW'($urandom); d1 = DW'($urandom);
         case ($urandom_range(0, 2))
            0: begin p0 = 1; p1 = 0; end
            1: begin p0 = 0; p1 = 1; end
            default: begin p0 = 1; p1 = 1; end
         endcase
         req0 = p0; op0 = o0; wdata0 = d0;
         req1 = p1; op1 = o1; wdata1 = d1;
         extra = 0;
         while (p0 || p1) begin
            w = (p0 && p1) ? ~last_m : p1;
            model_step(w, w ? o1 : o0, w ? d1 : d0, ee, el, ep, eq);
            grant_wait(lat, a0, a1, e, rd, own, dp, dq);
            tests++; if ({a0, a1} !== {~w, w} || own !== w) begin fails++; $display("FAIL rand_grant%0d: got ack=%b owner=%0d expected owner %0d", it, {a0, a1}, own, w); end
            tests++; if (lat !== el + extra) begin fails++; $display("FAIL rand_lat%0d: got %0d expected %0d", it, lat, el + extra); end
            tests++; if (e !== ee) begin fails++; $display("FAIL rand_err%0d: got %0d expected %0d", it, e, ee); end
            tests++; if (rd !== rd_m) begin fails++; $display("FAIL rand_rdata%0d: got %h expected %h", it, rd, rd_m); end
            tests++; if (dp !== ep || dq !== eq) begin fails++; $display("FAIL rand_strobes%0d: got %0d/%0d expected %0d/%0d", it, dp, dq, ep, eq); end
            if (w) begin req1 = 0; p1 = 0; end
            else   begin req0 = 0; p0 = 0; end
            extra = 1;
         end
      end
   endtask

   task automatic test_strobe_exclusive();
      tests++;
      if (nboth !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles expected 0", nboth); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_push_pop();
      test_pop_empty();
      test_contention();
      test_full();
      test_mid_reset();
      test_random();
      test_strobe_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
